// File: rtl/clint_timer_if.sv
// Data-memory bus slice between the address decoder and the machine timer.
`timescale 1ns/1ps
interface clint_timer_if;
  logic        timer_valid;
  logic        timer_instr;
  logic [31:0] timer_addr;
  logic [31:0] timer_wdata;
  logic [3:0]  timer_wstrb;
  logic [31:0] timer_rdata;
  logic        timer_ready;
  logic        timer_irpt;

  modport master (
    output timer_valid, timer_instr, timer_addr, timer_wdata, timer_wstrb,
    input  timer_rdata, timer_ready, timer_irpt
  );

  modport slave (
    input  timer_valid, timer_instr, timer_addr, timer_wdata, timer_wstrb,
    output timer_rdata, timer_ready, timer_irpt
  );
endinterface

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime/mtimecmp as four bus words, registered level irq while mtime >= mtimecmp.
// One-cycle response to every request, no stall.
`timescale 1ns/1ps
module clint_timer #(
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  clint_timer_if.slave bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_irpt;

  logic          w_tick;
  logic          w_wr;
  logic          w_rd;
  logic [1:0]    w_sel;
  logic [31:0]   w_old;
  logic [31:0]   w_wword;
  logic [63:0]   w_mtime_nxt;
  logic [63:0]   w_mtimecmp_nxt;
  logic          w_unused;

  assign w_unused = &{1'b0, bus.timer_instr, bus.timer_addr[31:4], bus.timer_addr[1:0]};

  assign w_tick = (r_count == LAST);
  assign w_wr   = bus.timer_valid & (|bus.timer_wstrb);
  assign w_rd   = bus.timer_valid & ~(|bus.timer_wstrb);
  assign w_sel  = bus.timer_addr[3:2];

  always_comb begin
    w_old = 32'd0;
    case (w_sel)
      2'd0:    w_old = r_mtime[31:0];
      2'd1:    w_old = r_mtime[63:32];
      2'd2:    w_old = r_mtimecmp[31:0];
      default: w_old = r_mtimecmp[63:32];
    endcase
  end

  always_comb begin
    w_wword = w_old;
    for (int i = 0; i < 4; i++) begin
      if (bus.timer_wstrb[i]) w_wword[8*i +: 8] = bus.timer_wdata[8*i +: 8];
    end
  end

  // A write to either mtime half suppresses that edge's increment entirely (no carry into the other half).
  always_comb begin
    w_mtime_nxt    = r_mtime;
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr && !w_sel[1]) begin
      if (w_sel[0]) w_mtime_nxt[63:32] = w_wword;
      else          w_mtime_nxt[31:0]  = w_wword;
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
    if (w_wr && w_sel[1]) begin
      if (w_sel[0]) w_mtimecmp_nxt[63:32] = w_wword;
      else          w_mtimecmp_nxt[31:0]  = w_wword;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_rdata    <= 32'd0;
      r_ready    <= 1'b0;
      r_irpt     <= 1'b0;
    end else begin
      r_count    <= w_tick ? '0 : r_count + CW'(1);
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_ready    <= bus.timer_valid;
      r_rdata    <= w_rd ? w_old : 32'd0;
      r_irpt     <= (r_mtime >= r_mtimecmp);
    end
  end

  assign bus.timer_rdata = r_rdata;
  assign bus.timer_ready = r_ready;
  assign bus.timer_irpt  = r_irpt;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: PRESCALE=1 instance for the bus/irq scenarios, PRESCALE=4 for the prescaler.
`timescale 1ns/1ps
module tb_clint_timer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;

  clint_timer_if bus1 ();
  clint_timer_if bus4 ();

  clint_timer #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  clint_timer #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus1.timer_valid = 1'b0; bus1.timer_instr = 1'b0; bus1.timer_addr = 32'd0;
    bus1.timer_wdata = 32'd0; bus1.timer_wstrb = 4'd0;
    bus4.timer_valid = 1'b0; bus4.timer_instr = 1'b0; bus4.timer_addr = 32'd0;
    bus4.timer_wdata = 32'd0; bus4.timer_wstrb = 4'd0;
  endtask

  // One request presented for one edge; outputs of that request are visible on return.
  task automatic op(input bit inst, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    if (inst) begin
      bus4.timer_valid = 1'b1; bus4.timer_addr = a; bus4.timer_wstrb = s; bus4.timer_wdata = d;
    end else begin
      bus1.timer_valid = 1'b1; bus1.timer_addr = a; bus1.timer_wstrb = s; bus1.timer_wdata = d;
      bus1.timer_instr = a[4];
    end
    tick();
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b0;
    #23;
    tests++; if (bus1.timer_ready !== 1'b0 || bus1.timer_rdata !== 32'd0 || bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: ready=%b rdata=%h irpt=%b required 0/0/0", bus1.timer_ready, bus1.timer_rdata, bus1.timer_irpt);
    end
    @(posedge clk); #1; rst = 1'b1;
    repeat (10) tick();
    op(0, 32'h0, 4'h0, 32'h0);
    tests++; if (bus1.timer_ready !== 1'b1) begin
      fails++; $display("FAIL first_read_ready: got %b required 1", bus1.timer_ready);
    end
    tests++; if (bus1.timer_rdata !== 32'd10) begin
      fails++; $display("FAIL first_read_rdata: got %h required %h", bus1.timer_rdata, 32'd10);
    end
    tests++; if (bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL first_read_irpt: got %b required 0", bus1.timer_irpt);
    end
    tick();
    tests++; if (bus1.timer_ready !== 1'b0 || bus1.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL ready_one_cycle: ready=%b rdata=%h required 0/0", bus1.timer_ready, bus1.timer_rdata);
    end
  endtask

  task automatic test_carry();
    op(0, 32'h0, 4'hF, 32'hFFFF_FFFF);
    tests++; if (bus1.timer_ready !== 1'b1 || bus1.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL write_response: ready=%b rdata=%h required 1/0", bus1.timer_ready, bus1.timer_rdata);
    end
    op(0, 32'h4, 4'hF, 32'h0);
    tick(); tick();
    op(0, 32'h4, 4'h0, 32'h0);
    tests++; if (bus1.timer_rdata !== 32'd1) begin
      fails++; $display("FAIL carry_hi: got %h required %h", bus1.timer_rdata, 32'd1);
    end
    op(0, 32'h0, 4'h0, 32'h0);
    tests++; if (bus1.timer_rdata !== 32'd2) begin
      fails++; $display("FAIL carry_lo: got %h required %h", bus1.timer_rdata, 32'd2);
    end
  endtask

  task automatic test_irpt();
    op(0, 32'h4, 4'hF, 32'h0);
    op(0, 32'h0, 4'hF, 32'h0);
    op(0, 32'hC, 4'hF, 32'h0);
    op(0, 32'h8, 4'hF, 32'd20);
    tests++; if (bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL irpt_after_cmp_write: got %b required 0", bus1.timer_irpt);
    end
    // mtime is 2 here; 18 more edges bring it to 20, the next edge registers the compare.
    repeat (18) tick();
    tests++; if (bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL irpt_before_match: got %b required 0", bus1.timer_irpt);
    end
    tick();
    tests++; if (bus1.timer_irpt !== 1'b1) begin
      fails++; $display("FAIL irpt_rise: got %b required 1", bus1.timer_irpt);
    end
    repeat (5) tick();
    tests++; if (bus1.timer_irpt !== 1'b1) begin
      fails++; $display("FAIL irpt_hold: got %b required 1", bus1.timer_irpt);
    end
    op(0, 32'hC, 4'hF, 32'd1);
    tests++; if (bus1.timer_irpt !== 1'b1) begin
      fails++; $display("FAIL irpt_lag: got %b required 1", bus1.timer_irpt);
    end
    tick();
    tests++; if (bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL irpt_fall: got %b required 0", bus1.timer_irpt);
    end
  endtask

  task automatic test_byte_strobe();
    op(0, 32'h8, 4'hF, 32'hFFFF_FFFF);
    op(0, 32'h8, 4'b0010, 32'h0000_AB00);
    tests++; if (bus1.timer_ready !== 1'b1 || bus1.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL strobe_write_resp: ready=%b rdata=%h required 1/0", bus1.timer_ready, bus1.timer_rdata);
    end
    op(0, 32'h8, 4'h0, 32'h0);
    tests++; if (bus1.timer_rdata !== 32'hFFFF_ABFF) begin
      fails++; $display("FAIL strobe_cmp_lo: got %h required %h", bus1.timer_rdata, 32'hFFFF_ABFF);
    end
    op(0, 32'hC, 4'h0, 32'h0);
    tests++; if (bus1.timer_rdata !== 32'd1) begin
      fails++; $display("FAIL strobe_cmp_hi: got %h required %h", bus1.timer_rdata, 32'd1);
    end
  endtask

  task automatic test_prescale();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (16) tick();
    op(1, 32'h0, 4'h0, 32'h0);
    tests++; if (bus4.timer_ready !== 1'b1 || bus4.timer_rdata !== 32'd4) begin
      fails++; $display("FAIL prescale_count: ready=%b rdata=%h required 1/%h", bus4.timer_ready, bus4.timer_rdata, 32'd4);
    end
    // Count is 1 after the read edge; two idle edges put the write on the tick edge.
    tick(); tick();
    op(1, 32'h0, 4'hF, 32'h100);
    op(1, 32'h0, 4'h0, 32'h0);
    tests++; if (bus4.timer_rdata !== 32'h100) begin
      fails++; $display("FAIL prescale_write_wins: got %h required %h", bus4.timer_rdata, 32'h100);
    end
    op(1, 32'h4, 4'h0, 32'h0);
    tests++; if (bus4.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL prescale_hi_untouched: got %h required %h", bus4.timer_rdata, 32'd0);
    end
    tick(); tick();
    op(1, 32'h0, 4'h0, 32'h0);
    tests++; if (bus4.timer_rdata !== 32'h101) begin
      fails++; $display("FAIL prescale_phase_kept: got %h required %h", bus4.timer_rdata, 32'h101);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    op(0, 32'hC, 4'hF, 32'h0);
    op(0, 32'h8, 4'hF, 32'h0);
    op(0, 32'h0, 4'h0, 32'h0);
    tests++; if (bus1.timer_ready !== 1'b1 || bus1.timer_rdata !== 32'd2 || bus1.timer_irpt !== 1'b1) begin
      fails++; $display("FAIL b2b_read0: ready=%b rdata=%h irpt=%b required 1/2/1", bus1.timer_ready, bus1.timer_rdata, bus1.timer_irpt);
    end
    op(0, 32'h4, 4'h0, 32'h0);
    tests++; if (bus1.timer_ready !== 1'b1 || bus1.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL b2b_read4: ready=%b rdata=%h required 1/0", bus1.timer_ready, bus1.timer_rdata);
    end
    bus1.timer_valid = 1'b1; bus1.timer_addr = 32'h8; bus1.timer_wstrb = 4'h0;
    tick();
    tests++; if (bus1.timer_ready !== 1'b1 || bus1.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL b2b_read8: ready=%b rdata=%h required 1/0", bus1.timer_ready, bus1.timer_rdata);
    end
    #1; rst = 1'b0;
    #1;
    tests++; if (bus1.timer_ready !== 1'b0 || bus1.timer_rdata !== 32'd0 || bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL mid_reset: ready=%b rdata=%h irpt=%b required 0/0/0", bus1.timer_ready, bus1.timer_rdata, bus1.timer_irpt);
    end
    idle_bus();
    tick();
    rst = 1'b1;
    op(0, 32'h0, 4'h0, 32'h0);
    tests++; if (bus1.timer_rdata !== 32'd0) begin
      fails++; $display("FAIL post_reset_mtime: got %h required 0", bus1.timer_rdata);
    end
    op(0, 32'hC, 4'h0, 32'h0);
    tests++; if (bus1.timer_rdata !== 32'hFFFF_FFFF || bus1.timer_irpt !== 1'b0) begin
      fails++; $display("FAIL post_reset_cmp: rdata=%h irpt=%b required FFFFFFFF/0", bus1.timer_rdata, bus1.timer_irpt);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_irpt();
    test_byte_strobe();
    test_prescale();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
